// File: rtl/oled_i2c_sequencer.sv
// SSD1306 transaction sequencer. On start it sends the 25-byte init list
// as one I2C write (addr, ctrl 0x00, list), then streams MSG_LEN message
// bytes as a second write (addr, ctrl 0x40, data). Bytes go to the shared
// I2C byte engine over a req/ack handshake. A NACKed transaction restarts
// from its address byte, up to MAX_RETRY extra attempts.
module oled_i2c_sequencer #(
   parameter logic [6:0]  DEV_ADDR  = 7'h3C,
   parameter int unsigned MSG_LEN   = 5,
   parameter int unsigned MAX_RETRY = 2,
   localparam int unsigned MSG_AW   = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [MSG_AW-1:0] msg_addr,
   input  logic [7:0]        msg_data,
   output logic              bus_req,
   output logic              bus_start,
   output logic              bus_stop,
   output logic [7:0]        bus_data,
   input  logic              bus_ack,
   input  logic              bus_nack
);

   typedef enum logic [3:0] {
      IDLE, C_ADDR, C_CTRL, C_BYTE, D_ADDR, D_CTRL, D_BYTE, GAP, FIN, ERR
   } state_t;

   localparam logic [7:0] ADDR_BYTE = {DEV_ADDR, 1'b0};
   localparam logic [7:0] CTRL_CMD  = 8'h00;
   localparam logic [7:0] CTRL_DATA = 8'h40;
   localparam int unsigned ROM_LEN  = 25;
   localparam logic [4:0] ROM_LAST  = 5'(ROM_LEN - 1);
   localparam logic [0:ROM_LEN-1][7:0] INIT_ROM = {
      8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
      8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
      8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
   };
   localparam logic [MSG_AW-1:0] MSG_LAST = MSG_AW'(MSG_LEN - 1);
   localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   state_t              r_state;
   state_t              r_pend;      // byte state to enter when GAP ends
   logic [4:0]          r_rom_idx;
   logic [MSG_AW-1:0]   r_msg_idx;
   logic [RETRY_W-1:0]  r_retry;
   logic                r_busy;
   logic                r_done;
   logic                r_error;
   logic                r_bus_req;
   logic                r_bus_start;
   logic                r_bus_stop;
   logic [7:0]          r_bus_data;

   logic [7:0]          w_load_data;
   logic                w_load_start;
   logic                w_load_stop;
   logic                w_in_cmd;

   assign busy      = r_busy;
   assign done      = r_done;
   assign error     = r_error;
   assign msg_addr  = r_msg_idx;
   assign bus_req   = r_bus_req;
   assign bus_start = r_bus_start;
   assign bus_stop  = r_bus_stop;
   assign bus_data  = r_bus_data;

   assign w_in_cmd = (r_state == C_ADDR) || (r_state == C_CTRL) || (r_state == C_BYTE);

   // Decode the byte and flags to present when GAP hands over to r_pend.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      w_load_data  = 8'h00;
      w_load_start = 1'b0;
      w_load_stop  = 1'b0;
      case (r_pend)
         C_ADDR, D_ADDR: begin
            w_load_data  = ADDR_BYTE;
            w_load_start = 1'b1;
         end
         C_CTRL: w_load_data = CTRL_CMD;
         C_BYTE: begin
            w_load_data = INIT_ROM[r_rom_idx];
            w_load_stop = (r_rom_idx == ROM_LAST);
         end
         D_CTRL: w_load_data = CTRL_DATA;
         D_BYTE: begin
            w_load_data = msg_data;
            w_load_stop = (r_msg_idx == MSG_LAST);
         end
         default: ;
      endcase
   end

   // Sequencer FSM with registered handshake and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_pend      <= IDLE;
         r_rom_idx   <= '0;
         r_msg_idx   <= '0;
         r_retry     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_bus_req   <= 1'b0;
         r_bus_start <= 1'b0;
         r_bus_stop  <= 1'b0;
         r_bus_data  <= 8'h00;
      end else begin
         // NOTE: non-blocking assignments keep every register updating from
         // the pre-edge values, independent of statement order.
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state     <= C_ADDR;
                  r_busy      <= 1'b1;
                  r_error     <= 1'b0;
                  r_retry     <= '0;
                  r_rom_idx   <= '0;
                  r_msg_idx   <= '0;
                  r_bus_req   <= 1'b1;
                  r_bus_data  <= ADDR_BYTE;
                  r_bus_start <= 1'b1;
                  r_bus_stop  <= 1'b0;
               end
            end
            GAP: begin
               r_state     <= r_pend;
               r_bus_req   <= 1'b1;
               r_bus_data  <= w_load_data;
               r_bus_start <= w_load_start;
               r_bus_stop  <= w_load_stop;
            end
            FIN, ERR: r_state <= IDLE;
            default: begin
               if (r_bus_req && bus_ack) begin
                  r_bus_req   <= 1'b0;
                  r_bus_start <= 1'b0;
                  r_bus_stop  <= 1'b0;
                  r_bus_data  <= 8'h00;
                  if (bus_nack) begin
                     if (r_retry < RETRY_MAX) begin
                        // Engine already sent STOP; restart this transaction.
                        r_retry   <= r_retry + 1'b1;
                        r_rom_idx <= '0;
                        r_msg_idx <= '0;
                        r_pend    <= w_in_cmd ? C_ADDR : D_ADDR;
                        r_state   <= GAP;
                     end else begin
                        r_state <= ERR;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_state <= GAP;
                     case (r_state)
                        C_ADDR: r_pend <= C_CTRL;
                        C_CTRL: r_pend <= C_BYTE;
                        C_BYTE: begin
                           if (r_rom_idx == ROM_LAST) begin
                              r_pend  <= D_ADDR;
                              r_retry <= '0;
                           end else begin
                              r_rom_idx <= r_rom_idx + 1'b1;
                              r_pend    <= C_BYTE;
                           end
                        end
                        D_ADDR: r_pend <= D_CTRL;
                        D_CTRL: r_pend <= D_BYTE;
                        D_BYTE: begin
                           if (r_msg_idx == MSG_LAST) begin
                              r_state <= FIN;
                              r_done  <= 1'b1;
                              r_busy  <= 1'b0;
                           end else begin
                              r_msg_idx <= r_msg_idx + 1'b1;
                              r_pend    <= D_BYTE;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oled_i2c_sequencer.sv
// Directed bench for oled_i2c_sequencer: a simple engine model acks bytes,
// logs the byte stream and compares it with hand-built expected streams.
module tb_oled_i2c_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       busy;
   logic       done;
   logic       error;
   logic [2:0] msg_addr;
   logic [7:0] msg_data;
   logic       bus_req;
   logic       bus_start;
   logic       bus_stop;
   logic [7:0] bus_data;
   logic       bus_ack;
   logic       bus_nack;

   localparam logic [7:0] EXP_ROM [25] = '{
      8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
      8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
      8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
   };
   localparam logic [7:0] MSG_MEM [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

   int checks;
   int failures;
   int done_cnt;
   int busy_err;
   int stab_err;
   int gap_err;
   int base_done;
   int req_seen;

   logic [7:0] q_d [$];
   logic       q_s [$];
   logic       q_p [$];
   logic [7:0] e_d [$];
   logic       e_s [$];
   logic       e_p [$];

   oled_i2c_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .msg_addr  (msg_addr),
      .msg_data  (msg_data),
      .bus_req   (bus_req),
      .bus_start (bus_start),
      .bus_stop  (bus_stop),
      .bus_data  (bus_data),
      .bus_ack   (bus_ack),
      .bus_nack  (bus_nack)
   );

   // Combinational message source.
   assign msg_data = (msg_addr < 3'd5) ? MSG_MEM[msg_addr] : 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count done pulses and any request raised while busy is low.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) done_cnt++;
      if (rst_n === 1'b1 && bus_req === 1'b1 && busy !== 1'b1) busy_err++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input logic s, input logic p);
      e_d.push_back(d);
      e_s.push_back(s);
      e_p.push_back(p);
   endtask

   // First n bytes of the 27-byte command transaction.
   task automatic push_cmd(input int n);
      for (int k = 0; k < n; k++) begin
         if (k == 0)      push_exp(8'h78, 1'b1, 1'b0);
         else if (k == 1) push_exp(8'h00, 1'b0, 1'b0);
         else             push_exp(EXP_ROM[k-2], 1'b0, (k == 26));
      end
   endtask

   task automatic push_data();
      push_exp(8'h78, 1'b1, 1'b0);
      push_exp(8'h40, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) push_exp(MSG_MEM[k], 1'b0, (k == 4));
   endtask

   task automatic clear_logs();
      q_d.delete(); q_s.delete(); q_p.delete();
      e_d.delete(); e_s.delete(); e_p.delete();
   endtask

   task automatic compare_log(input string tag);
      check({tag, "_len"}, q_d.size(), e_d.size());
      for (int i = 0; i < q_d.size() && i < e_d.size(); i++)
         check($sformatf("%s_byte%0d", tag, i),
               {22'd0, q_s[i], q_p[i], q_d[i]}, {22'd0, e_s[i], e_p[i], e_d[i]});
      clear_logs();
   endtask

   // Engine model: serve nbytes requests, logging each byte. Returns at the
   // negedge right after the last ack is released.
   task automatic serve(input int nbytes, input bit slow, input bit nack_addr,
                        input int nack_at, input int poke_at);
      int         waited;
      int         delay;
      bit         found;
      logic [7:0] d;
      logic       s;
      logic       p;
      for (int b = 0; b < nbytes; b++) begin
         waited = 0;
         found  = 1'b0;
         while (!found && waited < 200) begin
            @(negedge clk);
            found = (bus_req === 1'b1);
            if (!found) waited++;
         end
         if (!found) begin
            check("byte_wait_timeout", b, nbytes);
            return;
         end
         if (b > 0 && waited != 0) gap_err++;
         d = bus_data;
         s = bus_start;
         p = bus_stop;
         q_d.push_back(d);
         q_s.push_back(s);
         q_p.push_back(p);
         delay = 3;
         if (slow && (b == 0 || $urandom_range(0, 3) == 0)) delay = 50;
         for (int c = 0; c < delay; c++) begin
            @(negedge clk);
            if (bus_req !== 1'b1 || bus_data !== d || bus_start !== s || bus_stop !== p)
               stab_err++;
            start = (b == poke_at && c == 0);
         end
         start    = 1'b0;
         bus_ack  = 1'b1;
         bus_nack = (nack_addr && s) || (b == nack_at);
         @(posedge clk);
         @(negedge clk);
         bus_ack  = 1'b0;
         bus_nack = 1'b0;
         if (bus_req !== 1'b0) gap_err++;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      done_cnt  = 0;
      busy_err  = 0;
      stab_err  = 0;
      gap_err   = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      bus_ack   = 1'b0;
      bus_nack  = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_busy",     32'(busy),      0);
      check("rst_done",     32'(done),      0);
      check("rst_error",    32'(error),     0);
      check("rst_req",      32'(bus_req),   0);
      check("rst_bstart",   32'(bus_start), 0);
      check("rst_bstop",    32'(bus_stop),  0);
      check("rst_bdata",    32'(bus_data),  0);
      check("rst_msg_addr", 32'(msg_addr),  0);
      rst_n = 1'b1;
      @(negedge clk);

      // Nominal run.
      base_done = done_cnt;
      pulse_start();
      check("nom_busy_after_start", 32'(busy), 1);
      serve(34, 1'b0, 1'b0, -1, -1);
      check("nom_fin_done", 32'(done), 1);
      check("nom_fin_busy", 32'(busy), 0);
      @(negedge clk);
      check("nom_done_one_cycle", 32'(done), 0);
      @(negedge clk);
      check("nom_done_count", done_cnt - base_done, 1);
      check("nom_error", 32'(error), 0);
      push_cmd(27);
      push_data();
      compare_log("nom");

      // Single NACK on ROM byte 0x80 (5th command byte).
      base_done = done_cnt;
      pulse_start();
      serve(39, 1'b0, 1'b0, 4, -1);
      repeat (2) @(negedge clk);
      check("nack1_done_count", done_cnt - base_done, 1);
      check("nack1_error", 32'(error), 0);
      push_cmd(5);
      push_cmd(27);
      push_data();
      compare_log("nack1");

      // NACK on every address byte: three attempts, then error.
      base_done = done_cnt;
      pulse_start();
      serve(3, 1'b0, 1'b1, -1, -1);
      check("err_error", 32'(error), 1);
      check("err_busy", 32'(busy), 0);
      req_seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus_req === 1'b1) req_seen++;
      end
      check("err_no_more_req", req_seen, 0);
      check("err_error_sticky", 32'(error), 1);
      check("err_no_done", done_cnt - base_done, 0);
      for (int k = 0; k < 3; k++) push_exp(8'h78, 1'b1, 1'b0);
      compare_log("err");

      // New start clears error and runs normally.
      base_done = done_cnt;
      pulse_start();
      check("restart_error_cleared", 32'(error), 0);
      check("restart_busy", 32'(busy), 1);
      serve(34, 1'b0, 1'b0, -1, -1);
      repeat (2) @(negedge clk);
      check("restart_done_count", done_cnt - base_done, 1);
      push_cmd(27);
      push_data();
      compare_log("restart");

      // Slow engine with long ack delays.
      base_done = done_cnt;
      pulse_start();
      serve(34, 1'b1, 1'b0, -1, -1);
      repeat (2) @(negedge clk);
      check("slow_done_count", done_cnt - base_done, 1);
      push_cmd(27);
      push_data();
      compare_log("slow");
      check("stability_errors", stab_err, 0);
      check("gap_errors", gap_err, 0);
      check("busy_span_errors", busy_err, 0);

      // start mid-data transaction and in the FIN cycle is ignored.
      base_done = done_cnt;
      pulse_start();
      serve(34, 1'b0, 1'b0, -1, 30);
      check("ign_fin_done", 32'(done), 1);
      pulse_start();
      check("ign_busy_after_fin", 32'(busy), 0);
      req_seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus_req === 1'b1 || busy === 1'b1) req_seen++;
      end
      check("ign_no_new_txn", req_seen, 0);
      check("ign_done_count", done_cnt - base_done, 1);
      push_cmd(27);
      push_data();
      compare_log("ign");

      // Reset asserted while D_BYTE j=2 is on the bus.
      pulse_start();
      serve(31, 1'b0, 1'b0, -1, -1);
      req_seen = 0;
      while (bus_req !== 1'b1 && req_seen < 10) begin
         @(negedge clk);
         req_seen++;
      end
      check("mid_msg_addr", 32'(msg_addr), 2);
      check("mid_bus_data", 32'(bus_data), 32'h4C);
      #2 rst_n = 1'b0;
      #1;
      check("arst_req",      32'(bus_req),   0);
      check("arst_busy",     32'(busy),      0);
      check("arst_bdata",    32'(bus_data),  0);
      check("arst_bstart",   32'(bus_start), 0);
      check("arst_msg_addr", 32'(msg_addr),  0);
      check("arst_error",    32'(error),     0);
      push_cmd(27);
      push_data();
      e_d = e_d[0:30];
      e_s = e_s[0:30];
      e_p = e_p[0:30];
      compare_log("pre_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      base_done = done_cnt;
      pulse_start();
      serve(34, 1'b0, 1'b0, -1, -1);
      repeat (2) @(negedge clk);
      check("post_reset_done_count", done_cnt - base_done, 1);
      push_cmd(27);
      push_data();
      compare_log("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/oled_i2c_sequencer.md
Name: oled_i2c_sequencer

Overview:
Transaction sequencer for the SSD1306 OLED on the shared I2C byte engine. On a start pulse it runs two write transactions back-to-back: a command transaction that sends a fixed 25-byte power-up/init list, then a data transaction that streams MSG_LEN message bytes from an external byte source. It sits between the top-level display logic and the I2C byte engine, which owns SCL/SDA. It drives the engine with a req/ack byte handshake and retries a transaction when the slave NACKs.

Parameters:
DEV_ADDR, 7'h3C, 7-bit SSD1306 slave address. The address byte on the bus is {DEV_ADDR,1'b0}, which is 8'h78 by default.
MSG_LEN, 5, number of message bytes in the data transaction. Legal range 1..255.
MAX_RETRY, 2, number of re-attempts per transaction after a NACK. Total attempts = 1+MAX_RETRY.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse to begin init+message sequence; ignored while busy=1
busy  out  1  high from the cycle after an accepted start until done/error
done  out  1  one-cycle pulse when both transactions complete without error
error  out  1  sticky; set when retries are exhausted, cleared by the next accepted start
msg_addr  out  $clog2(MSG_LEN) (min 1)  index of the message byte currently requested
msg_data  in  8  message byte for msg_addr; combinational source, valid in the same cycle
bus_req  out  1  byte request to the engine; held with stable data/flags until bus_ack
bus_start  out  1  engine issues START before this byte
bus_stop  out  1  engine issues STOP after this byte
bus_data  out  8  byte to transmit
bus_ack  in  1  one-cycle pulse: engine finished the requested byte
bus_nack  in  1  valid only with bus_ack: slave NACKed; engine has already issued STOP

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, error, bus_req, bus_start, bus_stop = 0; bus_data=8'h00; msg_addr=0; indices and retry count cleared. Reset mid-transaction drops bus_req immediately. Bus release is the engine's responsibility.
- Init list (localparam ROM, 25 bytes, in order): AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
- States: IDLE, C_ADDR, C_CTRL, C_BYTE, D_ADDR, D_CTRL, D_BYTE, GAP, FIN, ERR.
- IDLE: a start pulse loads C_ADDR, sets busy, clears error and the retry count.
- Byte bytes per state:
  - C_ADDR: bus_data=8'h78 with bus_start=1.
  - C_CTRL: bus_data=8'h00.
  - C_BYTE: bus_data=ROM[i]; bus_stop=1 when i=24.
  - D_ADDR: bus_data=8'h78 with bus_start=1.
  - D_CTRL: bus_data=8'h40.
  - D_BYTE: bus_data=msg_data at msg_addr=j; bus_stop=1 when j=MSG_LEN-1.
- Handshake:
  - All bus_* outputs are registered and asserted together.
  - They remain stable while bus_req=1 and bus_ack=0.
  - In the cycle bus_ack=1, the FSM commits the next state. bus_req is 0 for exactly one cycle (GAP), and the next byte is presented on the following cycle.
  - Ack-to-next-req latency is 2 cycles. msg_data is sampled into bus_data at the GAP-to-D_BYTE load.
- Flags: bus_start/bus_stop are 0 on all bytes other than those listed. bus_ack while bus_req=0 is ignored.
- Transaction ends:
  - The ack of the last C_BYTE (no NACK) goes to D_ADDR via GAP, with retry count reset.
  - The ack of the last D_BYTE goes to FIN.
  - FIN: done=1 for one cycle and busy=0 in the same cycle, then IDLE.
- NACK handling (bus_ack=1 & bus_nack=1 in any byte state):
  - If retry count < MAX_RETRY: increment it, reset the byte index, and restart the current transaction from its ADDR state via GAP. The data transaction restarts at j=0; the init is not repeated.
  - Otherwise go to ERR: error=1 (sticky), busy=0, then IDLE.
- start while busy=1 is ignored, including in the FIN cycle.
- Simultaneous start and reset: reset wins.

Test Plan:
- Nominal: message source H,E,L,L,O; single start; engine acks each byte after 3 cycles -> 27-byte cmd txn 78 00 AE .. AF (start flag on 78, stop flag on AF), then 7-byte data txn 78 40 48 45 4C 4C 4F (stop on 4F); done pulses once; busy covers the whole span; error=0.
- NACK once on the 5th cmd-txn byte (ROM 80) -> STOP left to engine, next req is 78 with bus_start=1, full cmd txn resent, data txn follows, done=1, error=0.
- NACK on every address byte -> exactly 3 attempts of 78, then error=1, busy=0, no done; a new start clears error and retries.
- Slow engine: ack delayed 50 cycles on random bytes -> bus_req/bus_data/flags stable throughout; exactly one 1-cycle req gap after each ack.
- start pulsed mid-data-txn and in the FIN cycle -> ignored; byte stream unchanged; exactly one done.
- rst_n low during D_BYTE j=2 -> all outputs 0 asynchronously; after release a start runs the full sequence from 78 00 AE.
